// File: rtl/lsu_ctrl_pkg.sv
// lsu_ctrl_pkg
//   Shared LSU definitions. The op encodings are the funct3 values that the
//   execute stage also uses for its lsu_op decode. lsu_req_err() is the single
//   place that decides whether an incoming request is rejected (bad op or
//   misaligned address).
package lsu_ctrl_pkg;

   // Load ops (req_store = 0)
   localparam logic [2:0] LSU_LB  = 3'd0;
   localparam logic [2:0] LSU_LH  = 3'd1;
   localparam logic [2:0] LSU_LW  = 3'd2;
   localparam logic [2:0] LSU_LBU = 3'd4;
   localparam logic [2:0] LSU_LHU = 3'd5;

   // Store ops (req_store = 1)
   localparam logic [2:0] LSU_SB  = 3'd0;
   localparam logic [2:0] LSU_SH  = 3'd1;
   localparam logic [2:0] LSU_SW  = 3'd2;

   // op[1:0] is the access size for every valid op: 0 byte, 1 half, 2 word.
   function automatic logic lsu_req_err(input logic       store,
                                        input logic [2:0] op,
                                        input logic [1:0] lane);
      logic bad_op;
      logic misaligned;
      if (store) bad_op = (op > LSU_SW);
      else       bad_op = (op == 3'd3) || (op > LSU_LHU);
      misaligned = ((op[1:0] == 2'b01) && lane[0]) ||
                   ((op[1:0] == 2'b10) && (lane != 2'b00));
      return bad_op || misaligned;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align
//   Purely combinational byte/half lane logic for the LSU.
//   i_op    : LSU op (load or store encoding, see lsu_ctrl_pkg)
//   i_lane  : byte address bits [1:0]
//   i_word  : word read from RAM
//   i_wdata : right-aligned store data
//   o_load  : extracted and sign/zero-extended load result
//   o_merge : i_word with the addressed byte/half replaced by store data
//             (for SW this is simply i_wdata)
module lsu_align
   import lsu_ctrl_pkg::*;
(
   input  logic [2:0]  i_op,
   input  logic [1:0]  i_lane,
   input  logic [31:0] i_word,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_load,
   output logic [31:0] o_merge
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte = i_word[{i_lane, 3'b000} +: 8];
      w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];

      case (i_op)
         LSU_LB:  o_load = {{24{w_byte[7]}}, w_byte};
         LSU_LBU: o_load = {24'h0, w_byte};
         LSU_LH:  o_load = {{16{w_half[15]}}, w_half};
         LSU_LHU: o_load = {16'h0, w_half};
         LSU_LW:  o_load = i_word;
         default: o_load = 32'h0;
      endcase

      o_merge = i_word;
      case (i_op)
         LSU_SB:  o_merge[{i_lane, 3'b000} +: 8] = i_wdata[7:0];
         LSU_SH:  begin
            if (i_lane[1]) o_merge[31:16] = i_wdata[15:0];
            else           o_merge[15:0]  = i_wdata[15:0];
         end
         default: o_merge = i_wdata;
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl
//   Load/store unit between execute and a single-port word RAM (registered
//   read, 1-cycle latency, no byte enables). Sub-word stores are done by
//   read-modify-write.
//   clk, rst          : clock, synchronous active-high reset
//   req_*             : request from execute (valid/ready)
//   resp_valid/err    : one-cycle completion pulse, err qualifies it
//   resp_rdata        : extended load data, 0 unless a successful load
//   ram_addr/wren/wdata, ram_rdata : RAM port
//   dbg_state         : current FSM state, for observation only
//
// Handshake: a request transfers on a rising edge where req_valid and
//   req_ready are both high. req_ready is high only in IDLE, so the request
//   fields need only be valid in that cycle; anything presented while busy is
//   ignored. There is no response backpressure: resp_valid is a single-cycle
//   pulse that the consumer must take.
module lsu_ctrl
   import lsu_ctrl_pkg::*;
#(
   parameter int ADDR_W = 7
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_store,
   input  logic [2:0]        req_op,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic              resp_err,
   output logic [31:0]       resp_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_wren,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata,
   output logic [2:0]        dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE, S_RD, S_WR, S_MERGE, S_RESP, S_ERR
   } state_t;

   state_t            r_state;
   logic              r_store;
   logic [2:0]        r_op;
   logic [1:0]        r_lane;
   logic [31:0]       r_wdata;
   logic [ADDR_W-1:0] r_ram_addr;
   logic              r_ready;
   logic              r_resp_valid;
   logic              r_resp_err;
   logic              r_wren;

   logic              w_accept;
   logic [31:0]       w_load_word;
   logic [31:0]       w_merge_word;
   // Address bits above the RAM window are deliberately ignored (aliasing).
   logic              w_unused;

   assign w_accept = req_valid && r_ready;
   assign w_unused = &{1'b0, req_addr[31:ADDR_W+2]};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_store      <= 1'b0;
         r_op         <= 3'd0;
         r_lane       <= 2'd0;
         r_wdata      <= 32'h0;
         r_ram_addr   <= '0;
         r_ready      <= 1'b1;
         r_resp_valid <= 1'b0;
         r_resp_err   <= 1'b0;
         r_wren       <= 1'b0;
      end else begin
         r_resp_valid <= 1'b0;
         r_resp_err   <= 1'b0;
         r_wren       <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_store    <= req_store;
                  r_op       <= req_op;
                  r_lane     <= req_addr[1:0];
                  r_wdata    <= req_wdata;
                  r_ram_addr <= req_addr[ADDR_W+1:2];
                  r_ready    <= 1'b0;
                  if (lsu_req_err(req_store, req_op, req_addr[1:0])) begin
                     r_state      <= S_ERR;
                     r_resp_valid <= 1'b1;
                     r_resp_err   <= 1'b1;
                  end else if (req_store && (req_op == LSU_SW)) begin
                     r_state <= S_WR;
                     r_wren  <= 1'b1;
                  end else begin
                     // Loads and sub-word stores both need the old word first.
                     r_state <= S_RD;
                  end
               end
            end
            S_RD: begin
               if (r_store) begin
                  r_state <= S_MERGE;
                  r_wren  <= 1'b1;
               end else begin
                  r_state      <= S_RESP;
                  r_resp_valid <= 1'b1;
               end
            end
            S_WR, S_MERGE: begin
               r_state      <= S_RESP;
               r_resp_valid <= 1'b1;
            end
            default: begin
               r_state <= S_IDLE;
               r_ready <= 1'b1;
            end
         endcase
      end
   end

   lsu_align u_align (
      .i_op    (r_op),
      .i_lane  (r_lane),
      .i_word  (ram_rdata),
      .i_wdata (r_wdata),
      .o_load  (w_load_word),
      .o_merge (w_merge_word)
   );

   assign req_ready  = r_ready;
   assign resp_valid = r_resp_valid;
   assign resp_err   = r_resp_err;
   assign ram_addr   = r_ram_addr;
   assign dbg_state  = r_state;
   // Reset kills a write in the same cycle, so an interrupted RMW leaves the
   // RAM untouched.
   assign ram_wren   = r_wren && !rst;

   // RAM read data only arrives in RESP/MERGE, so these paths are
   // combinational from ram_rdata.
   assign resp_rdata = ((r_state == S_RESP) && !r_store) ? w_load_word : 32'h0;
   assign ram_wdata  = (r_state == S_MERGE) ? w_merge_word :
                       (r_state == S_WR)    ? r_wdata      : 32'h0;

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;
   import lsu_ctrl_pkg::*;

   localparam int ADDR_W = 7;
   localparam int DEPTH  = 1 << ADDR_W;

   // ------------------------------------------------------------------
   // Clock / reset / DUT
   // ------------------------------------------------------------------
   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic              req_store = 1'b0;
   logic [2:0]        req_op = 3'd0;
   logic [31:0]       req_addr = 32'h0;
   logic [31:0]       req_wdata = 32'h0;
   logic              resp_valid;
   logic              resp_err;
   logic [31:0]       resp_rdata;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_wren;
   logic [31:0]       ram_wdata;
   logic [31:0]       ram_rdata;
   logic [2:0]        dbg_state;

   always #5 clk = ~clk;

   lsu_ctrl #(.ADDR_W(ADDR_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_store  (req_store),
      .req_op     (req_op),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_err   (resp_err),
      .resp_rdata (resp_rdata),
      .ram_addr   (ram_addr),
      .ram_wren   (ram_wren),
      .ram_wdata  (ram_wdata),
      .ram_rdata  (ram_rdata),
      .dbg_state  (dbg_state)
   );

   // ------------------------------------------------------------------
   // RAM model (registered read, read-before-write) and reference memory
   // ------------------------------------------------------------------
   logic [31:0] mem     [DEPTH];
   logic [31:0] ref_mem [DEPTH];
   logic        init_en = 1'b0;

   always @(posedge clk) begin
      if (init_en) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= ref_mem[i];
      end else if (ram_wren) begin
         mem[ram_addr] <= ram_wdata;
      end
      ram_rdata <= mem[ram_addr];
   end

   // ------------------------------------------------------------------
   // Scoreboard counters and compare helper
   // ------------------------------------------------------------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, got, exp);
      end
   endtask

   // ------------------------------------------------------------------
   // Reference model: a memory request described by access size in bytes,
   // shifts and masks over a plain word array.
   // ------------------------------------------------------------------
   function automatic void model(input logic st, input logic [2:0] op,
                                 input logic [31:0] addr, input logic [31:0] wd,
                                 output logic e_err, output logic [31:0] e_rd,
                                 output int e_lat, output logic e_wr,
                                 output logic [31:0] e_wdata);
      int          size;
      int          sh;
      int          widx;
      logic        op_ok;
      logic [31:0] old;
      logic [31:0] mask;
      size  = 1 << op[1:0];
      sh    = 8 * int'(addr[1:0]);
      widx  = int'(addr[ADDR_W+1:2]);
      op_ok = st ? (op <= 3'd2) : (op inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      e_err = !op_ok || ((addr & 32'(size - 1)) != 32'h0);
      old   = ref_mem[widx];
      mask  = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * size)) - 32'h1);
      e_rd    = 32'h0;
      e_wr    = 1'b0;
      e_wdata = 32'h0;
      if (e_err) begin
         e_lat = 1;
      end else if (!st) begin
         e_lat = 2;
         e_rd  = (old >> sh) & mask;
         if (!op[2] && size < 4 && e_rd[8 * size - 1]) e_rd = e_rd | ~mask;
      end else begin
         e_lat   = (size == 4) ? 2 : 3;
         e_wr    = 1'b1;
         e_wdata = (old & ~(mask << sh)) | ((wd & mask) << sh);
         ref_mem[widx] = e_wdata;
      end
   endfunction

   // ------------------------------------------------------------------
   // Driver: issue one request and check the whole transaction
   // ------------------------------------------------------------------
   task automatic do_req(input string name, input logic st, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic e_err, input logic [31:0] e_rd, input int e_lat,
                         input logic e_wr, input logic [31:0] e_wdata);
      int                lat;
      int                wcnt;
      logic              seen;
      logic [31:0]       got_wdata;
      logic [ADDR_W-1:0] got_waddr;
      logic [ADDR_W-1:0] e_addr;
      e_addr    = addr[ADDR_W+1:2];
      got_wdata = 32'h0;
      got_waddr = '0;
      @(negedge clk);
      chk({name, " ready_before"}, 32'(req_ready), 32'h1);
      req_valid = 1'b1;
      req_store = st;
      req_op    = op;
      req_addr  = addr;
      req_wdata = wd;
      @(posedge clk);
      #1;
      // Scramble the request bus: nothing after the accept edge may matter.
      req_valid = 1'b0;
      req_store = 1'($urandom_range(0, 1));
      req_op    = 3'($urandom_range(0, 7));
      req_addr  = $urandom;
      req_wdata = $urandom;
      lat  = 0;
      wcnt = 0;
      seen = 1'b0;
      while (!seen && lat < 8) begin
         @(negedge clk);
         lat++;
         if (ram_wren) begin
            wcnt++;
            got_wdata = ram_wdata;
            got_waddr = ram_addr;
         end
         chk({name, " ready_busy"}, 32'(req_ready), 32'h0);
         chk({name, " ram_addr"}, 32'(ram_addr), 32'(e_addr));
         if (resp_valid) begin
            seen = 1'b1;
            chk({name, " latency"}, 32'(lat), 32'(e_lat));
            chk({name, " resp_err"}, 32'(resp_err), 32'(e_err));
            chk({name, " resp_rdata"}, resp_rdata, e_rd);
         end
      end
      if (!seen) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s timeout: no resp_valid within %0d cycles, expected %0d", name, lat, e_lat);
      end
      chk({name, " wren_cycles"}, 32'(wcnt), e_wr ? 32'h1 : 32'h0);
      if (e_wr) begin
         chk({name, " wr_addr"}, 32'(got_waddr), 32'(e_addr));
         chk({name, " wr_data"}, got_wdata, e_wdata);
      end
      @(negedge clk);
      chk({name, " ready_after"}, 32'(req_ready), 32'h1);
      chk({name, " resp_after"}, 32'(resp_valid), 32'h0);
   endtask

   // ------------------------------------------------------------------
   // Directed vector table
   // ------------------------------------------------------------------
   typedef struct {
      string       name;
      logic        st;
      logic [2:0]  op;
      logic [31:0] addr;
      logic [31:0] wd;
      logic        e_err;
      logic [31:0] e_rd;
      int          e_lat;
      logic        e_wr;
      logic [31:0] e_wdata;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input string name, input logic st, input logic [2:0] op,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic e_err, input logic [31:0] e_rd, input int e_lat,
                      input logic e_wr, input logic [31:0] e_wdata);
      vec_t v;
      v.name = name; v.st = st; v.op = op; v.addr = addr; v.wd = wd;
      v.e_err = e_err; v.e_rd = e_rd; v.e_lat = e_lat; v.e_wr = e_wr; v.e_wdata = e_wdata;
      vecs.push_back(v);
   endtask

   // ------------------------------------------------------------------
   // Main sequence
   // ------------------------------------------------------------------
   initial begin
      logic        m_err, m_wr;
      logic [31:0] m_rd, m_wdata;
      int          m_lat;
      logic        st;
      logic [2:0]  op;
      logic [31:0] addr;
      logic [31:0] wd;
      int          k;
      logic        exp_rdy [6];
      logic        exp_rv  [6];
      logic [31:0] exp_rd  [6];

      for (int i = 0; i < DEPTH; i++) ref_mem[i] = $urandom;
      ref_mem[3] = 32'h8081_82F3;
      ref_mem[5] = 32'h1122_3344;

      // Reset, with RAM image loaded while the DUT is held in reset
      rst = 1'b1;
      init_en = 1'b1;
      @(posedge clk);
      #1 init_en = 1'b0;
      @(negedge clk);
      chk("rst_wren_low", 32'(ram_wren), 32'h0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset req_ready", 32'(req_ready), 32'h1);
      chk("reset resp_valid", 32'(resp_valid), 32'h0);
      chk("reset resp_err", 32'(resp_err), 32'h0);
      chk("reset resp_rdata", resp_rdata, 32'h0);
      chk("reset ram_wren", 32'(ram_wren), 32'h0);
      chk("reset ram_addr", 32'(ram_addr), 32'h0);
      chk("reset ram_wdata", ram_wdata, 32'h0);

      //   name        st    op       addr          wdata         err   rdata          lat wr    wdata
      add("lb_0c",    1'b0, LSU_LB,  32'h0000_000C, 32'h0,        1'b0, 32'hFFFF_FFF3, 2, 1'b0, 32'h0);
      add("lbu_0f",   1'b0, LSU_LBU, 32'h0000_000F, 32'h0,        1'b0, 32'h0000_0080, 2, 1'b0, 32'h0);
      add("lh_0e",    1'b0, LSU_LH,  32'h0000_000E, 32'h0,        1'b0, 32'hFFFF_8081, 2, 1'b0, 32'h0);
      add("lhu_0c",   1'b0, LSU_LHU, 32'h0000_000C, 32'h0,        1'b0, 32'h0000_82F3, 2, 1'b0, 32'h0);
      add("lw_0c",    1'b0, LSU_LW,  32'h0000_000C, 32'h0,        1'b0, 32'h8081_82F3, 2, 1'b0, 32'h0);
      add("sw_10",    1'b1, LSU_SW,  32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0,        2, 1'b1, 32'hDEAD_BEEF);
      add("lw_10",    1'b0, LSU_LW,  32'h0000_0010, 32'h0,        1'b0, 32'hDEAD_BEEF, 2, 1'b0, 32'h0);
      add("sb_11",    1'b1, LSU_SB,  32'h0000_0011, 32'h1234_56AA, 1'b0, 32'h0,        3, 1'b1, 32'hDEAD_AAEF);
      add("sh_12",    1'b1, LSU_SH,  32'h0000_0012, 32'h0000_5555, 1'b0, 32'h0,        3, 1'b1, 32'h5555_AAEF);
      add("lw_12",    1'b0, LSU_LW,  32'h0000_0012, 32'h0,        1'b1, 32'h0,         1, 1'b0, 32'h0);
      add("ld_op3",   1'b0, 3'd3,    32'h0000_0010, 32'h0,        1'b1, 32'h0,         1, 1'b0, 32'h0);
      add("sh_13",    1'b1, LSU_SH,  32'h0000_0013, 32'h0000_FFFF, 1'b1, 32'h0,        1, 1'b0, 32'h0);
      add("st_op3",   1'b1, 3'd3,    32'h0000_0010, 32'h1111_1111, 1'b1, 32'h0,        1, 1'b0, 32'h0);
      add("ld_op7",   1'b0, 3'd7,    32'h0000_0010, 32'h0,        1'b1, 32'h0,         1, 1'b0, 32'h0);
      add("lh_11",    1'b0, LSU_LH,  32'h0000_0011, 32'h0,        1'b1, 32'h0,         1, 1'b0, 32'h0);
      add("lw_alias", 1'b0, LSU_LW,  32'h0000_0210, 32'h0,        1'b0, 32'h5555_AAEF, 2, 1'b0, 32'h0);
      add("lb_11",    1'b0, LSU_LB,  32'h0000_0011, 32'h0,        1'b0, 32'hFFFF_FFAA, 2, 1'b0, 32'h0);
      add("lhu_12",   1'b0, LSU_LHU, 32'h0000_0012, 32'h0,        1'b0, 32'h0000_5555, 2, 1'b0, 32'h0);

      foreach (vecs[i]) begin
         // Keep the reference memory in step with the directed stores.
         model(vecs[i].st, vecs[i].op, vecs[i].addr, vecs[i].wd, m_err, m_rd, m_lat, m_wr, m_wdata);
         do_req(vecs[i].name, vecs[i].st, vecs[i].op, vecs[i].addr, vecs[i].wd,
                vecs[i].e_err, vecs[i].e_rd, vecs[i].e_lat, vecs[i].e_wr, vecs[i].e_wdata);
      end

      // Reset during the MERGE cycle of an SB to word 5
      @(negedge clk);
      req_valid = 1'b1;
      req_store = 1'b1;
      req_op    = LSU_SB;
      req_addr  = 32'h0000_0014;
      req_wdata = 32'h0000_00AA;
      @(posedge clk);          // accept -> RD
      #1 req_valid = 1'b0;
      @(posedge clk);          // RD -> MERGE
      #1 rst = 1'b1;
      @(negedge clk);
      chk("rmw_rst wren", 32'(ram_wren), 32'h0);
      chk("rmw_rst resp_valid", 32'(resp_valid), 32'h0);
      @(posedge clk);
      #1 rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("rmw_rst no_resp", 32'(resp_valid), 32'h0);
         chk("rmw_rst no_wren", 32'(ram_wren), 32'h0);
         chk("rmw_rst ready", 32'(req_ready), 32'h1);
      end
      chk("rmw_rst mem5", mem[5], 32'h1122_3344);
      do_req("rmw_rst readback", 1'b0, LSU_LW, 32'h0000_0014, 32'h0,
             1'b0, 32'h1122_3344, 2, 1'b0, 32'h0);

      // Back-to-back loads with req_valid held high
      exp_rdy[0] = 1'b0; exp_rv[0] = 1'b0; exp_rd[0] = 32'h0;
      exp_rdy[1] = 1'b0; exp_rv[1] = 1'b1; exp_rd[1] = 32'hFFFF_FFF3;
      exp_rdy[2] = 1'b1; exp_rv[2] = 1'b0; exp_rd[2] = 32'h0;
      exp_rdy[3] = 1'b0; exp_rv[3] = 1'b0; exp_rd[3] = 32'h0;
      exp_rdy[4] = 1'b0; exp_rv[4] = 1'b1; exp_rd[4] = 32'h0000_8081;
      exp_rdy[5] = 1'b1; exp_rv[5] = 1'b0; exp_rd[5] = 32'h0;
      @(negedge clk);
      chk("b2b ready_start", 32'(req_ready), 32'h1);
      req_valid = 1'b1;
      req_store = 1'b0;
      req_op    = LSU_LB;
      req_addr  = 32'h0000_000C;
      @(posedge clk);
      #1;
      req_op   = LSU_LHU;
      req_addr = 32'h0000_000E;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         chk($sformatf("b2b ready c%0d", c + 1), 32'(req_ready), 32'(exp_rdy[c]));
         chk($sformatf("b2b resp_valid c%0d", c + 1), 32'(resp_valid), 32'(exp_rv[c]));
         chk($sformatf("b2b resp_rdata c%0d", c + 1), resp_rdata, exp_rd[c]);
         if (c == 3) req_valid = 1'b0;
      end

      // Randomized requests against the reference model
      for (int n = 0; n < 60; n++) begin
         st = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 4) == 0) begin
            op = 3'($urandom_range(0, 7));
         end else if (st) begin
            op = 3'($urandom_range(0, 2));
         end else begin
            k  = int'($urandom_range(0, 4));
            op = (k > 2) ? 3'(k + 1) : 3'(k);
         end
         addr = (32'($urandom_range(0, 7)) << 9) | 32'($urandom_range(0, 63));
         if ($urandom_range(0, 2) != 0) addr = addr & ~((32'h1 << op[1:0]) - 32'h1);
         wd = $urandom;
         model(st, op, addr, wd, m_err, m_rd, m_lat, m_wr, m_wdata);
         do_req($sformatf("rnd%0d", n), st, op, addr, wd, m_err, m_rd, m_lat, m_wr, m_wdata);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Absolute guard against a hang anywhere in the sequence
   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete, checks %0d errors %0d", n_checks, n_errors);
      $fatal(1);
   end

endmodule
